// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the fetch stage: FSM state encoding,
// the HALT opcode and the program's branch-target table.
// BRANCH_LUT mirrors the assembler's label map; regenerate both together.

package fetch_pkg;

    localparam int LUT_W = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [8:0] HALT_OPCODE = 9'h1FF;

    localparam logic [LUT_W-1:0] BRANCH_LUT [0:15] = '{
        12'd50,   12'd2,    12'd4095, 12'd100,
        12'd6,    12'd20,   12'd300,  12'd1024,
        12'd2048, 12'd7,    12'd4000, 12'd333,
        12'd15,   12'd1,    12'd777,  12'd3000
    };

endpackage

// File: rtl/branch_lut.sv
// branch_lut
// Combinational index-to-target lookup over fetch_pkg::BRANCH_LUT.
// Kept separate so the table can be swapped per program.
// Ports:
//   idx    in  IDX_W  LUT entry selector
//   target out LUT_W  branch target address

module branch_lut
    import fetch_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    output logic [LUT_W-1:0] target
);

    assign target = BRANCH_LUT[idx];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Owns the program counter and fetch sequencing ahead of instruction memory.
// Applies branch / relative-jump / stall requests and detects HALT.
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   start          in   begin execution from address 0 (IDLE/HALTED only)
//   stall          in   hold PC and cycle counter
//   instruction    in   9-bit word fetched at current_pc
//   branch_taken   in   load PC from branch LUT (wins over rel_jump_en)
//   branch_lut_idx in   LUT entry for the branch target
//   rel_jump_en    in   add sign-extended rel_offset to PC
//   rel_offset     in   8-bit two's-complement offset
//   current_pc     out  fetch address, upper bits zero
//   running        out  high in RUN
//   done           out  high from HALT until next accepted start
//   cycle_count    out  non-stalled RUN cycles since last start (saturating)
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// RUN    | fetching, PC advances every non-stalled cycle
// HALTED | HALT seen, PC parked on the HALT address, done high

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int IMEM_AW   = 12,
    parameter int LUT_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic [8:0]           instruction,
    input  logic                 branch_taken,
    input  logic [LUT_IDX_W-1:0] branch_lut_idx,
    input  logic                 rel_jump_en,
    input  logic [7:0]           rel_offset,
    output logic [31:0]          current_pc,
    output logic                 running,
    output logic                 done,
    output logic [31:0]          cycle_count
);

    state_t             state;
    logic [IMEM_AW-1:0] pc;
    logic [IMEM_AW-1:0] pc_next;
    logic [LUT_W-1:0]   lut_target;

    branch_lut #(.IDX_W(LUT_IDX_W)) u_branch_lut (
        .idx    (branch_lut_idx),
        .target (lut_target)
    );

    // Truncating adds give the modulo-2^IMEM_AW wrap for free.
    always_comb begin
        pc_next = pc + 1'b1;
        if (branch_taken) begin
            pc_next = IMEM_AW'(lut_target);
        end else if (rel_jump_en) begin
            pc_next = pc + {{(IMEM_AW-8){rel_offset[7]}}, rel_offset};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= '0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state       <= RUN;
                        pc          <= '0;
                        done        <= 1'b0;
                        cycle_count <= '0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (cycle_count != 32'hFFFF_FFFF) begin
                            cycle_count <= cycle_count + 32'd1;
                        end
                        // HALT parks the PC on the HALT word's own address.
                        if (instruction == HALT_OPCODE) begin
                            state <= HALTED;
                            done  <= 1'b1;
                        end else begin
                            pc <= pc_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign current_pc = {{(32-IMEM_AW){1'b0}}, pc};
    assign running    = (state == RUN);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic [8:0]  instruction;
    logic        branch_taken;
    logic [3:0]  branch_lut_idx;
    logic        rel_jump_en;
    logic [7:0]  rel_offset;
    logic [31:0] current_pc;
    logic        running;
    logic        done;
    logic [31:0] cycle_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int              m_pc;
    bit              m_running;
    bit              m_done;
    longint unsigned m_cc;

    int lut [16] = '{50, 2, 4095, 100, 6, 20, 300, 1024,
                     2048, 7, 4000, 333, 15, 1, 777, 3000};

    fetch_unit #(.IMEM_AW(12), .LUT_IDX_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stall          (stall),
        .instruction    (instruction),
        .branch_taken   (branch_taken),
        .branch_lut_idx (branch_lut_idx),
        .rel_jump_en    (rel_jump_en),
        .rel_offset     (rel_offset),
        .current_pc     (current_pc),
        .running        (running),
        .done           (done),
        .cycle_count    (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},      current_pc,           32'(m_pc));
        chk({tag, ".running"}, {31'd0, running},     {31'd0, m_running});
        chk({tag, ".done"},    {31'd0, done},        {31'd0, m_done});
        chk({tag, ".cycles"},  cycle_count,          32'(m_cc));
    endtask

    task automatic model_reset();
        m_pc = 0; m_running = 0; m_done = 0; m_cc = 0;
    endtask

    // Behavioural rules applied to the inputs present at the rising edge.
    task automatic model_edge();
        if (m_running) begin
            if (!stall) begin
                if (m_cc < 64'hFFFF_FFFF) m_cc = m_cc + 1;
                if (instruction == 9'h1FF) begin
                    m_running = 0;
                    m_done    = 1;
                end else if (branch_taken) begin
                    m_pc = lut[branch_lut_idx];
                end else if (rel_jump_en) begin
                    m_pc = (m_pc + int'($signed(rel_offset))) & 4095;
                end else begin
                    m_pc = (m_pc + 1) % 4096;
                end
            end
        end else if (start) begin
            m_running = 1; m_done = 0; m_pc = 0; m_cc = 0;
        end
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; instruction = 9'h000; branch_taken = 0;
        branch_lut_idx = 0; rel_jump_en = 0; rel_offset = 0;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #12;
        chk_all("reset");

        // Release reset with start already high: RUN on first edge.
        start = 1;
        #1 reset = 1'b1;
        tick("start_in_reset");
        start = 0;

        // Program: 0 at addresses 0..3, HALT at 4.
        for (int i = 0; i < 5; i++) begin
            instruction = (m_pc == 4) ? 9'h1FF : 9'h000;
            tick("seq");
        end
        chk("halt_pc", current_pc, 32'd4);
        chk("halt_cycles", cycle_count, 32'd5);
        chk("halt_done", {31'd0, done}, 32'd1);

        // start while HALTED restarts at 0 and clears done.
        instruction = 9'h000;
        start = 1;
        tick("restart");
        start = 0;
        chk("restart_done", {31'd0, done}, 32'd0);

        // start in RUN is ignored.
        start = 1; tick("start_in_run");
        start = 0; tick("to_pc2");
        chk("at_pc2", current_pc, 32'd2);

        branch_taken = 1; branch_lut_idx = 3;
        tick("branch_idx3");
        chk("branch_to_100", current_pc, 32'd100);
        branch_taken = 0;

        rel_jump_en = 1; rel_offset = 8'(-90);
        tick("rel_to_10");
        chk("at_pc10", current_pc, 32'd10);

        branch_taken = 1; branch_lut_idx = 0; rel_offset = 8'd7;
        tick("branch_wins");
        chk("branch_wins_50", current_pc, 32'd50);

        branch_lut_idx = 1; rel_jump_en = 0;
        tick("branch_to_2");
        branch_taken = 0; rel_jump_en = 1; rel_offset = 8'(-5);
        tick("rel_neg_wrap");
        chk("wrap_4093", current_pc, 32'd4093);

        rel_jump_en = 0; branch_taken = 1; branch_lut_idx = 2;
        tick("branch_to_4095");
        branch_taken = 0;
        tick("inc_wrap");
        chk("wrap_0", current_pc, 32'd0);

        // Stall over a HALT word at PC 6.
        branch_taken = 1; branch_lut_idx = 4;
        tick("branch_to_6");
        branch_taken = 0;
        stall = 1; instruction = 9'h1FF;
        for (int i = 0; i < 3; i++) tick("stall");
        chk("stall_pc", current_pc, 32'd6);
        chk("stall_no_done", {31'd0, done}, 32'd0);
        stall = 0;
        tick("unstall_halt");
        chk("unstall_done", {31'd0, done}, 32'd1);

        // Asynchronous reset mid-RUN at PC 20.
        instruction = 9'h000; start = 1;
        tick("restart2");
        start = 0; branch_taken = 1; branch_lut_idx = 5;
        tick("branch_to_20");
        branch_taken = 0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk_all("async_reset");
        #3 reset = 1'b1;
        start = 1;
        tick("restart3");
        start = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            start          = ($urandom_range(0, 9) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            branch_taken   = ($urandom_range(0, 6) == 0);
            branch_lut_idx = 4'($urandom_range(0, 15));
            rel_jump_en    = ($urandom_range(0, 4) == 0);
            rel_offset     = 8'($urandom_range(0, 255));
            instruction    = ($urandom_range(0, 29) == 0) ? 9'h1FF
                                                          : 9'($urandom_range(0, 510));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-sequencing stage that sits directly upstream of the instruction memory. It owns the PC register and drives `current_pc` into the instruction memory. It takes the returned 9-bit instruction back so it can detect HALT. It applies taken-branch, relative-jump and stall requests from the decode/execute side, and exposes the start/done handshake used by the testbench and top level.

## Interface
Parameters:
- `IMEM_AW`, 12, instruction-memory address width; PC arithmetic wraps modulo 2^IMEM_AW.
- `LUT_IDX_W`, 4, width of the branch-target LUT index (16 entries).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request to begin execution from address 0.
- `stall`  in  1  hold PC and counters this cycle.
- `instruction`  in  9  current instruction returned by instruction memory.
- `branch_taken`  in  1  load PC from branch LUT.
- `branch_lut_idx`  in  LUT_IDX_W  LUT entry selecting the branch target.
- `rel_jump_en`  in  1  add a signed offset to PC.
- `rel_offset`  in  8  two's-complement PC offset.
- `current_pc`  out  32  fetch address; bits [31:IMEM_AW] always 0.
- `running`  out  1  high while in RUN.
- `done`  out  1  high from HALT detection until the next accepted start.
- `cycle_count`  out  32  number of non-stalled RUN cycles since the last start.

## Operation
- FSM states: IDLE, RUN, HALTED.
- Reset (reset=0, any time, asynchronous):
  - State goes to IDLE.
  - `current_pc`=0, `done`=0, `running`=0, `cycle_count`=0.
- IDLE:
  - `start`=1 moves to RUN.
  - PC=0 and `cycle_count`=0 on entry.
- RUN, per cycle, with this priority:
  - `stall`: PC and `cycle_count` hold, no HALT check.
  - `instruction`==HALT_OPCODE (9'h1FF): go to HALTED, PC holds on the HALT address, `done`=1.
  - `branch_taken`: PC = BRANCH_LUT[`branch_lut_idx`].
  - `rel_jump_en`: PC = (PC + sign-extended `rel_offset`) mod 2^IMEM_AW.
  - Otherwise PC = (PC + 1) mod 2^IMEM_AW.
  - `cycle_count` increments every non-stalled RUN cycle, including the cycle that detects HALT. It saturates at 32'hFFFF_FFFF.
- `start` while in RUN is ignored.
- HALTED:
  - `done` holds 1; PC and `cycle_count` hold.
  - `start`=1 goes to RUN with PC=0, `cycle_count`=0, `done`=0.
- `branch_taken` and `rel_jump_en` asserted together: the branch wins.
- Wrap-around: PC 4095 + 1 gives 0. PC 2 + (−5) gives 4093.

## Timing
- All outputs are registered except `running`, which is decoded from the state register.
- `current_pc` changes only after a rising edge, so instruction memory sees a stable address for the whole cycle.
- Redirect latency is 1 cycle: a redirect request seen at edge N gives the new PC after edge N; no delay slot.
- HALT is detected in the same cycle the HALT word is presented. `done` rises after that edge.
- Start to first fetch: the edge sampling `start` enters RUN with PC=0. Address 0 is fetched in the following cycle.
- Reset mid-RUN: outputs return to their reset values immediately, independent of `clk`. Leaving reset with `start` already high enters RUN on the first edge after release.

## Structure
- `fetch_pkg` holds:
  - `state_t` enum {IDLE, RUN, HALTED}.
  - `HALT_OPCODE` = 9'h1FF.
  - `BRANCH_LUT`, a 16×12-bit constant table shared with the assembler's label map.
- Sub-module `branch_lut`: purely combinational index-to-target lookup over `BRANCH_LUT`. This keeps the table swappable per program.
- `fetch_unit` contains the FSM, PC register, next-PC mux and cycle counter.

## Test plan
- Reset then `start` pulse, with instructions 9'h000 at addresses 0..3 and 9'h1FF at 4:
  - PC sequence is 0,1,2,3,4.
  - `done`=1 one edge after PC=4; `cycle_count`=5.
- `branch_taken`=1 with idx 3 (LUT[3]=12'd100) at PC=2: next PC=100.
- Simultaneous `branch_taken` (LUT[0]=12'd50) and `rel_jump_en` (offset +7) at PC=10: next PC=50.
- `rel_offset`=−5 at PC=2 gives 4093; plain increment at PC=4095 gives 0.
- `stall` held 3 cycles at PC=6 while a HALT word is presented:
  - PC stays 6, `cycle_count` frozen, no `done`.
  - After `stall` drops, `done` rises 1 edge later.
- Drive `reset`=0 between edges at PC=20: all outputs go to 0 without a clock edge. Re-`start` from HALTED clears `done` and restarts at PC=0.
